// File: rtl/dm_bridge.sv
// dm_bridge: holds the memory stage while one load/store runs over a req/ack bus with a timeout abort
module dm_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [3:0]  wea_mem,
  input  logic [31:0] Data_write_to_dm,
  output logic [31:0] Data_read_from_dm,
  output logic        stall,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic [31:0] rd_q;
  logic        wr, acc;
  assign wr = mem_w & (|wea_mem);
  assign acc = wr | mem_r;
  assign stall = ((state == IDLE) & acc) | (state == REQ);
  assign Data_read_from_dm = rd_q;
  // Transaction FSM: latch the access in IDLE, wait for ack or timeout in REQ, release the pipe for one DONE cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= '0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          state     <= REQ;
          bus_req   <= 1'b1;
          bus_we    <= wr;
          bus_addr  <= {Addr_in[31:2], 2'b00};
          bus_be    <= wr ? wea_mem : 4'b1111;
          bus_wdata <= wr ? Data_write_to_dm : 32'h0;
        end
        REQ: if (bus_ack) begin
          state   <= DONE;
          bus_req <= 1'b0;
          cnt     <= '0;
          rd_q    <= bus_we ? rd_q : bus_rdata;
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          state   <= DONE;
          bus_req <= 1'b0;
          cnt     <= '0;
          rd_q    <= 32'h0;
          bus_err <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_bridge.sv
// tb_dm_bridge: table-driven scoreboard bench for dm_bridge with TIMEOUT=4
module tb_dm_bridge;
  logic        clk = 0, rstn = 0;
  logic        mem_r = 0, mem_w = 0, bus_ack = 0;
  logic [31:0] Addr_in = 0, Data_write_to_dm = 0, bus_rdata = 0;
  logic [3:0]  wea_mem = 0;
  logic [31:0] Data_read_from_dm, bus_addr, bus_wdata;
  logic        stall, bus_err, bus_req, bus_we;
  logic [3:0]  bus_be;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  dm_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .mem_r(mem_r), .mem_w(mem_w), .Addr_in(Addr_in),
    .wea_mem(wea_mem), .Data_write_to_dm(Data_write_to_dm),
    .Data_read_from_dm(Data_read_from_dm), .stall(stall), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        r, w;
    logic [3:0]  wea;
    logic [31:0] addr, wdata, rdata;
    int          ack_at;
    logic        x_we;
    logic [3:0]  x_be;
    logic [31:0] x_addr, x_wdata, x_rd;
    logic        x_err;
    int          x_stall, x_reqc;
  } vec_t;

  vec_t        tbl[9];
  vec_t        sbq[$];
  logic [31:0] rq[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic vec_t mk(logic r, logic w, logic [3:0] wea, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int ack_at, logic x_we, logic [3:0] x_be,
                              logic [31:0] x_addr, logic [31:0] x_wdata, logic [31:0] x_rd,
                              logic x_err, int x_stall, int x_reqc);
    vec_t v;
    v.r = r; v.w = w; v.wea = wea; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_at = ack_at; v.x_we = x_we; v.x_be = x_be; v.x_addr = x_addr; v.x_wdata = x_wdata;
    v.x_rd = x_rd; v.x_err = x_err; v.x_stall = x_stall; v.x_reqc = x_reqc;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    vec_t x;
    int   sc = 0, rc = 0;
    bit   done = 0;
    @(posedge clk); #1;
    mem_r = v.r; mem_w = v.w; wea_mem = v.wea; Addr_in = v.addr; Data_write_to_dm = v.wdata;
    sbq.push_back(v);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus_req) begin
        rc++;
        chk($sformatf("v%0d bus_we", idx), {31'h0, bus_we}, {31'h0, sbq[0].x_we});
        chk($sformatf("v%0d bus_be", idx), {28'h0, bus_be}, {28'h0, sbq[0].x_be});
        chk($sformatf("v%0d bus_addr", idx), bus_addr, sbq[0].x_addr);
        chk($sformatf("v%0d bus_wdata", idx), bus_wdata, sbq[0].x_wdata);
        bus_ack = (rc - 1 == v.ack_at);
        bus_rdata = v.rdata;
        Addr_in = ~v.addr; Data_write_to_dm = ~v.wdata; wea_mem = ~v.wea;
      end else bus_ack = 0;
      if (stall) sc++; else done = 1;
    end
    if (!done) begin
      errors++;
      $display("FAIL v%0d stall never released", idx);
    end
    x = sbq.pop_front();
    chk($sformatf("v%0d stall_cycles", idx), sc, x.x_stall);
    chk($sformatf("v%0d req_cycles", idx), rc, x.x_reqc);
    chk($sformatf("v%0d rdata", idx), Data_read_from_dm, x.x_rd);
    chk($sformatf("v%0d bus_err", idx), {31'h0, bus_err}, {31'h0, x.x_err});
    mem_r = 0; mem_w = 0; bus_ack = 0;
    @(negedge clk);
    chk($sformatf("v%0d err_after", idx), {31'h0, bus_err}, 32'h0);
    chk($sformatf("v%0d stall_after", idx), {31'h0, stall}, 32'h0);
  endtask

  initial begin
    int  tx, dn, rc;
    bit  prev;
    tbl[0] = mk(1, 0, 4'h0, 32'h1006, 32'h0, 32'hA5A51234, 0, 0, 4'hF, 32'h1004, 32'h0, 32'hA5A51234, 0, 2, 1);
    tbl[1] = mk(0, 1, 4'h4, 32'h2000, 32'h77777777, 32'hDEADBEEF, 2, 1, 4'h4, 32'h2000, 32'h77777777, 32'hA5A51234, 0, 4, 3);
    tbl[2] = mk(1, 0, 4'h0, 32'h30, 32'h0, 32'h55555555, 255, 0, 4'hF, 32'h30, 32'h0, 32'h0, 1, 5, 4);
    tbl[3] = mk(1, 1, 4'h3, 32'h44, 32'h12345678, 32'h99999999, 1, 1, 4'h3, 32'h44, 32'h12345678, 32'h0, 0, 3, 2);
    tbl[4] = mk(0, 1, 4'h0, 32'h50, 32'hABCDABCD, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    tbl[5] = mk(1, 0, 4'h0, 32'hFFFFFFFF, 32'h0, 32'h13579BDF, 1, 0, 4'hF, 32'hFFFFFFFC, 32'h0, 32'h13579BDF, 0, 3, 2);
    tbl[6] = mk(0, 1, 4'hF, 32'h8, 32'hCAFEF00D, 32'h0, 255, 1, 4'hF, 32'h8, 32'hCAFEF00D, 32'h0, 1, 5, 4);
    tbl[7] = mk(1, 0, 4'h0, 32'h7C, 32'h0, 32'h0BADF00D, 3, 0, 4'hF, 32'h7C, 32'h0, 32'h0BADF00D, 0, 5, 4);
    tbl[8] = tbl[0];
    repeat (2) @(negedge clk);
    chk("rst bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_be", {28'h0, bus_be}, 32'h0);
    chk("rst rdata", Data_read_from_dm, 32'h0);
    chk("rst stall", {31'h0, stall}, 32'h0);
    rstn = 1;
    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);
    @(posedge clk); #1;
    mem_r = 1; Addr_in = 32'h500; rc = 0;
    for (int c = 0; c < 10 && rc < 2; c++) begin
      @(negedge clk);
      if (bus_req) rc++;
    end
    chk("rst_req reached", rc, 2);
    rstn = 0;
    #1;
    chk("rst_req drop", {31'h0, bus_req}, 32'h0);
    mem_r = 0;
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    chk("post_rst stall", {31'h0, stall}, 32'h0);
    chk("post_rst bus_we", {31'h0, bus_we}, 32'h0);
    chk("post_rst bus_addr", bus_addr, 32'h0);
    chk("post_rst bus_wdata", bus_wdata, 32'h0);
    chk("post_rst rdata", Data_read_from_dm, 32'h0);
    chk("post_rst bus_err", {31'h0, bus_err}, 32'h0);
    @(posedge clk); #1;
    mem_r = 1; Addr_in = 32'h600;
    rq.push_back(32'h11112222); rq.push_back(32'h33334444);
    tx = 0; dn = 0; prev = 0;
    for (int c = 0; c < 20 && dn < 2; c++) begin
      @(negedge clk);
      if (bus_req) begin
        if (!prev) tx++;
        bus_ack = 1;
        bus_rdata = (rq.size() > 0) ? rq[0] : 32'h0;
      end else bus_ack = 0;
      if (prev && !bus_req && rq.size() > 0) begin
        chk($sformatf("b2b rdata%0d", dn), Data_read_from_dm, rq.pop_front());
        chk($sformatf("b2b stall%0d", dn), {31'h0, stall}, 32'h0);
        dn++;
        if (dn == 2) mem_r = 0;
      end
      prev = bus_req;
    end
    repeat (2) @(negedge clk);
    chk("b2b transactions", tx, 2);
    chk("b2b completions", dn, 2);
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    chk("stray rdata", Data_read_from_dm, 32'h33334444);
    chk("stray bus_req", {31'h0, bus_req}, 32'h0);
    chk("stray stall", {31'h0, stall}, 32'h0);
    bus_ack = 0;
    run_vec(tbl[8], 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
